serializer: RTL and testbench
=============================

// Module: serializer
// PURPOSE
//   Parallel-in, serial-out converter. Captures a WIDTH-bit word when valid_data is
//   sampled high and the block is ready, then shifts it out one bit per clk, LSB first.
//   Sits between a parallel data source and a 1-bit serial link. Back-to-back words are
//   sent with no gap cycles while valid_data is held high.
// PARAMETERS
//   WIDTH       8    parallel word width in bits (>= 2)
//   IDLE_LEVEL  1'b0 level driven on out_data when no word is being sent
// PORTS
//   clk         in   1      clock; all state updates on the rising edge
//   rst         in   1      asynchronous, active-high reset
//   in_data     in   WIDTH  parallel word; sampled only on a load edge
//   valid_data  in   1      request to load in_data
//   out_data    out  1      serial bit stream, registered
//   out_valid   out  1      high while out_data carries a payload bit, registered
//   ready       out  1      high when a load can occur on the next rising edge
//   last_bit    out  1      high while out_data carries bit WIDTH-1 of the word
// BEHAVIOUR
//   - One clock (clk); reset is asynchronous and active-high (rst).
//   - Reset values: out_data=IDLE_LEVEL, out_valid=0, last_bit=0, ready=1,
//     shift register=0, bit counter=0, state=IDLE. Asserting rst mid-word aborts the word;
//     after release, the first rising edge with valid_data=1 loads a new word.
//   - States: IDLE (nothing in flight) and SHIFT (word in flight).
//   - Load edge: a rising edge where valid_data=1 and ready=1.
//       in_data is captured; out_data<=in_data[0]; out_valid<=1; counter<=0;
//       state<=SHIFT. Bit 0 is on out_data for the cycle after the load edge.
//   - SHIFT: each edge advances one bit, so out_data holds bit i for clock cycle i
//     after the load edge (i = 0..WIDTH-1). last_bit=1 while bit WIDTH-1 is presented.
//   - ready = (state==IDLE) | last_bit. This allows a reload on the edge that ends the
//     last bit, giving gapless framing: with valid_data held high, words are loaded every
//     WIDTH cycles.
//   - End of word: on the edge ending bit WIDTH-1, if valid_data=1, perform a load edge
//     (the next word's bit 0 follows immediately). If valid_data=0:
//     out_data<=IDLE_LEVEL, out_valid<=0, state<=IDLE.
//   - Changes to in_data and valid_data between load edges are ignored. The word in
//     flight is never altered.
//   - valid_data is ignored while a word is in flight and not on its last bit.
//   - Latency: 1 clk from the load edge to bit 0 on out_data. A word occupies exactly
//     WIDTH cycles.
//   - Counter width is clog2(WIDTH). It never exceeds WIDTH-1.
// TESTING
//   1. rst=1 with clk running -> out_data=0, out_valid=0, ready=1. Assert rst
//      asynchronously between edges -> outputs clear immediately.
//   2. Hold valid_data=1 with in_data=8'b01010011 -> after the first edge, out_data
//      sequence is 1,1,0,0,1,0,1,0. last_bit is high on the 8th bit only.
//   3. Keep valid_data=1 and change in_data to 8'b11001111 mid-word -> the current word
//      finishes unchanged. The next word (loaded at the 8-cycle boundary) is
//      1,1,1,1,0,0,1,1 with no gap cycle.
//   4. Load one word, then drop valid_data before the last bit -> after 8 bits,
//      out_valid=0, out_data=0, ready=1.
//   5. Pulse valid_data mid-word with a different in_data -> ignored. Output stream and
//      ready timing are unchanged.
//   6. Assert rst on bit 3 of a word -> outputs reset. The next load sends a fresh
//      word starting at bit 0.

Source files
------------

// File: rtl/serializer_if.sv
// serializer_if: parallel-source / serial-link bundle for the serializer
//   in_data, valid_data : parallel word and load request (source -> serializer)
//   ready               : serializer can accept a load on the next rising edge
//   out_data, out_valid : registered serial bit and its payload qualifier
//   last_bit            : out_data currently carries bit WIDTH-1
interface serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] in_data;
    logic             valid_data;
    logic             ready;
    logic             out_data;
    logic             out_valid;
    logic             last_bit;
    modport master (output in_data, valid_data, input ready, out_data, out_valid, last_bit);
    modport slave  (input in_data, valid_data, output ready, out_data, out_valid, last_bit);
endinterface

// File: rtl/serializer.sv
// serializer: parallel-in, serial-out converter, LSB first, gapless back-to-back words
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serializer_if.slave (in_data/valid_data in; ready/out_data/out_valid/last_bit out)
module serializer #(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    serializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             last_bit_q, last_bit_d;
    logic             ready;
    logic             load;
    // Accepting on the last bit lets the next word follow with no gap cycle.
    assign ready        = (state_q == IDLE) | last_bit_q;
    assign load         = bus.valid_data & ready;
    assign bus.ready    = ready;
    assign bus.out_data = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.last_bit = last_bit_q;
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        last_bit_d  = last_bit_q;
        if (load) begin
            state_d     = SHIFT;
            shift_d     = bus.in_data;
            cnt_d       = '0;
            out_data_d  = bus.in_data[0];
            out_valid_d = 1'b1;
            last_bit_d  = 1'b0;
        end else if (last_bit_q) begin
            state_d     = IDLE;
            cnt_d       = '0;
            out_data_d  = IDLE_LEVEL;
            out_valid_d = 1'b0;
            last_bit_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            // shift_q[0] is the bit on the wire; the next one is always at index 1.
            shift_d    = shift_q >> 1;
            out_data_d = shift_q[1];
            cnt_d      = cnt_q + 1'b1;
            last_bit_d = cnt_q == CW'(WIDTH - 2);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= IDLE_LEVEL;
            out_valid_q <= 1'b0;
            last_bit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            last_bit_q  <= last_bit_d;
        end
    end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: directed self-checking bench for serializer
module tb_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    serializer_if #(.WIDTH(8)) bus ();
    serializer #(.WIDTH(8), .IDLE_LEVEL(1'b0)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_data"}, 32'(bus.out_data), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_last"}, 32'(bus.last_bit), 0);
        chk({tag, "_ready"}, 32'(bus.ready), 1);
    endtask
    // Checks one word already on the wire (bit 0 presented now); at bit a drives
    // valid_data=va/in_data=da, at bit b drives valid_data=vb. Returns on bit 7.
    task automatic word(input string tag, input logic [7:0] w, input int a, input logic va,
                        input logic [7:0] da, input int b, input logic vb);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_bit%0d", tag, i), 32'(bus.out_data), 32'(w[i]));
            chk($sformatf("%s_val%0d", tag, i), 32'(bus.out_valid), 1);
            chk($sformatf("%s_last%0d", tag, i), 32'(bus.last_bit), 32'(i == 7));
            chk($sformatf("%s_rdy%0d", tag, i), 32'(bus.ready), 32'(i == 7));
            if (i == a) begin
                bus.valid_data = va;
                bus.in_data    = da;
            end
            if (i == b) bus.valid_data = vb;
            if (i < 7) tick();
        end
    endtask
    initial begin
        bus.valid_data = 1'b0;
        bus.in_data    = '0;
        tick();
        tick();
        chk_idle("rst_hold");
        rst = 1'b0;
        bus.valid_data = 1'b1;
        bus.in_data    = 8'hFF;
        tick();
        bus.valid_data = 1'b0;
        chk("pre_async_valid", 32'(bus.out_valid), 1);
        #2 rst = 1'b1;
        #1 chk_idle("async_rst");
        #1 rst = 1'b0;
        tick();
        chk_idle("after_rel");
        bus.valid_data = 1'b1;
        bus.in_data    = 8'b01010011;
        tick();
        word("w1", 8'b01010011, 3, 1'b1, 8'b11001111, -1, 1'b0);
        tick();
        word("w2", 8'b11001111, 2, 1'b0, 8'h00, -1, 1'b0);
        tick();
        chk_idle("drop");
        bus.valid_data = 1'b1;
        bus.in_data    = 8'hA5;
        tick();
        bus.valid_data = 1'b0;
        word("w5", 8'hA5, 3, 1'b1, 8'h0F, 4, 1'b0);
        tick();
        chk_idle("pulse_end");
        bus.valid_data = 1'b1;
        bus.in_data    = 8'h3C;
        tick();
        bus.valid_data = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("w6_bit%0d", i), 32'(bus.out_data), 32'((8'h3C >> i) & 8'h01));
            tick();
        end
        chk("w6_bit3", 32'(bus.out_data), 1);
        chk("w6_val3", 32'(bus.out_valid), 1);
        #2 rst = 1'b1;
        #1 chk_idle("rst_bit3");
        #1 rst = 1'b0;
        tick();
        chk_idle("rst_bit3_rel");
        bus.valid_data = 1'b1;
        bus.in_data    = 8'h96;
        tick();
        bus.valid_data = 1'b0;
        word("w7", 8'h96, -1, 1'b0, 8'h00, -1, 1'b0);
        tick();
        chk_idle("final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
